// File: rtl/wb_arbiter_if.sv
// Wishbone-style point-to-point bus used for both master ports and the memory port.
// The memory port has no error line, so the master modport leaves err out.
interface wb_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              cs;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              err;

    modport master (output addr, cs, we, wdata, input rdata, ack);
    modport slave  (input addr, cs, we, wdata, output rdata, ack, err);
endinterface

// File: rtl/wb_arbiter.sv
// Two-master round-robin arbiter onto one memory port, with a per-grant watchdog
// that aborts a stalled transfer with a single-cycle error pulse.
//
// state     | meaning
// ST_IDLE   | no grant; bus outputs held at zero, pending requests arbitrated
// ST_GRANT0 | M0 owns the memory port for one transfer
// ST_GRANT1 | M1 owns the memory port for one transfer
module wb_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    wb_arbiter_if.slave  m0,
    wb_arbiter_if.slave  m1,
    wb_arbiter_if.master s
);
    localparam int WDOG_W = $clog2(TIMEOUT) + 1;
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [DATA_W-1:0] DATA_ZERO = '0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_GRANT0 = 3'b010,
        ST_GRANT1 = 3'b100
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last;
    logic [WDOG_W-1:0] r_wdog;
    logic              w_timeout;

    assign w_timeout = (r_wdog == WDOG_MAX);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_wdog  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == ST_IDLE) begin
                r_wdog <= '0;
            end else if (r_state != ST_IDLE) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (r_state == ST_GRANT0 && w_next == ST_IDLE) begin
                r_last <= 1'b0;
            end else if (r_state == ST_GRANT1 && w_next == ST_IDLE) begin
                r_last <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        s.addr   = ADDR_ZERO;
        s.cs     = 1'b0;
        s.we     = 1'b0;
        s.wdata  = DATA_ZERO;
        m0.rdata = DATA_ZERO;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m1.rdata = DATA_ZERO;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // On a tie the master that was not served last wins.
                if (m0.cs && m1.cs) begin
                    w_next = r_last ? ST_GRANT0 : ST_GRANT1;
                end else if (m0.cs) begin
                    w_next = ST_GRANT0;
                end else if (m1.cs) begin
                    w_next = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                s.addr   = m0.addr;
                s.cs     = m0.cs;
                s.we     = m0.we;
                s.wdata  = m0.wdata;
                m0.rdata = s.rdata;
                m0.ack   = s.ack;
                if (s.ack || !m0.cs) begin
                    w_next = ST_IDLE;
                end else if (w_timeout) begin
                    m0.err = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_GRANT1: begin
                s.addr   = m1.addr;
                s.cs     = m1.cs;
                s.we     = m1.we;
                s.wdata  = m1.wdata;
                m1.rdata = s.rdata;
                m1.ack   = s.ack;
                if (s.ack || !m1.cs) begin
                    w_next = ST_IDLE;
                end else if (w_timeout) begin
                    m1.err = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end
endmodule
